// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with a decoupled imem request/response port, a prefetch
// queue of {pc, instr} entries and discard of in-flight responses on redirect.
module if_stage_fq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              FQ_DEPTH  = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            pc_src,
    input  logic [XLEN-1:0] new_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instruction,
    output logic            if_id_valid
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    // Wide enough to hold outst + fq_count without overflow.
    localparam int CW = PW + 2;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FQ_DEPTH);
    localparam logic [CW-1:0]   MAX_C      = CW'(MAX_OUTST);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fq_pc_mem    [FQ_DEPTH];
    logic [XLEN-1:0] fq_instr_mem [FQ_DEPTH];

    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   outst_reg;
    logic [CW-1:0]   drop_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [XLEN-1:0] if_id_pc_reg;
    logic [XLEN-1:0] if_id_instr_reg;
    logic            if_id_valid_reg;

    logic            accept;
    logic            resp_take;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc;

    always_comb begin
        imem_req_valid = !reset && !pc_src && (outst_reg < MAX_C)
                         && ((outst_reg + count_reg) < DEPTH_C);
        imem_req_addr  = fetch_pc_reg;
        accept         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp_take      = imem_resp_valid && (outst_reg != '0);
        // Responses landing on a redirect cycle belong to the old stream.
        push           = resp_take && (drop_reg == '0) && !pc_src;
        pop            = (count_reg != '0) && !pc_src && (flush || !stall);
        redirect_pc    = new_pc & ALIGN_MASK;
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            assert (count_reg < DEPTH_C);
            fq_pc_mem[wr_ptr_reg]    <= resp_pc_reg;
            fq_instr_mem[wr_ptr_reg] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            outst_reg       <= '0;
            drop_reg        <= '0;
            if_id_pc_reg    <= '0;
            if_id_instr_reg <= NOP_INSTR;
            if_id_valid_reg <= 1'b0;
        end else begin
            outst_reg <= outst_reg + CW'(accept) - CW'(resp_take);

            if (pc_src) begin
                // Everything still in flight belongs to the abandoned stream.
                fetch_pc_reg <= redirect_pc;
                resp_pc_reg  <= redirect_pc;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                count_reg    <= '0;
                drop_reg     <= outst_reg - CW'(resp_take);
            end else begin
                if (accept) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (push) begin
                    wr_ptr_reg  <= wr_ptr_reg + PW'(1);
                    resp_pc_reg <= resp_pc_reg + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
                if (resp_take && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CW'(1);
                end
            end

            if (flush) begin
                if_id_pc_reg    <= '0;
                if_id_instr_reg <= NOP_INSTR;
                if_id_valid_reg <= 1'b0;
            end else if (stall) begin
                if_id_pc_reg    <= if_id_pc_reg;
                if_id_instr_reg <= if_id_instr_reg;
                if_id_valid_reg <= if_id_valid_reg;
            end else if (!pc_src && (count_reg != '0)) begin
                if_id_pc_reg    <= fq_pc_mem[rd_ptr_reg];
                if_id_instr_reg <= fq_instr_mem[rd_ptr_reg];
                if_id_valid_reg <= 1'b1;
            end else begin
                if_id_pc_reg    <= '0;
                if_id_instr_reg <= NOP_INSTR;
                if_id_valid_reg <= 1'b0;
            end
        end
    end

    assign if_id_pc          = if_id_pc_reg;
    assign if_id_instruction = if_id_instr_reg;
    assign if_id_valid       = if_id_valid_reg;
endmodule

// File: tb/tb_if_stage_fq.sv
// Directed bench for if_stage_fq: a queue-based imem model with selectable latency,
// a per-cycle vector table for streaming/stall/flush, and hand sequences for redirects and reset.
`timescale 1ns/1ps
module tb_if_stage_fq;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] new_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'hDEAD_BEEF;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat    = 1;
    int cyc    = 0;

    always #5 clk = ~clk;

    if_stage_fq dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .pc_src            (pc_src),
        .new_pc            (new_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_1000: return 32'h1000_0237;
            32'h0000_1008: return 32'h0050_0293;
            default:       return {a[15:0], 16'h0A13};
        endcase
    endfunction

    // imem model: handshakes sampled mid-cycle, acted on at the following edge.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    logic        acc_s  = 1'b0;
    logic        cons_s = 1'b0;
    logic        rst_s  = 1'b1;
    logic [31:0] addr_s = '0;

    always @(negedge clk) begin
        acc_s  = imem_req_valid && imem_req_ready;
        cons_s = imem_resp_valid;
        rst_s  = reset;
        addr_s = imem_req_addr;
    end

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            mq.delete();
        end else begin
            if (cons_s && mq.size() > 0) void'(mq.pop_front());
            if (acc_s) mq.push_back('{addr_s, cyc + lat - 1});
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] pc,
                            input logic [31:0] instr, input logic v);
        chk({name, "_pc"}, if_id_pc, pc);
        chk({name, "_instr"}, if_id_instruction, instr);
        chk({name, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    endtask

    task automatic chk_req(input string name, input logic v, input logic [31:0] addr);
        chk({name, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
        if (v) chk({name, "_req_addr"}, imem_req_addr, addr);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc, input logic [31:0] instr);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_id_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no valid IF/ID, want pc 0x%08h within 20 cycles", name, pc);
        end else begin
            chk({name, "_pc"}, if_id_pc, pc);
            chk({name, "_instr"}, if_id_instruction, instr);
        end
        $display("%s: if_id pc=0x%08h instr=0x%08h valid=%b", name, if_id_pc, if_id_instruction, if_id_valid);
    endtask

    task automatic do_reset(input int l);
        reset  = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        pc_src = 1'b0;
        new_pc = '0;
        lat    = l;
        tick();
        chk_ifid("reset", 32'h0, NOP, 1'b0);
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Streaming from reset, 4-cycle stall until credit runs out, then a one-cycle flush.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h00, 32'h00, NOP,              1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 32'h00, NOP,              1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h08, 32'h00, 32'h0000_0013,    1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 32'h04, 32'h0010_0093,    1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h04, 32'h0010_0093,    1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h14, 32'h04, 32'h0010_0093,    1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h04, 32'h0010_0093,    1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h04, 32'h0010_0093,    1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h08, mem_word(32'h08), 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h18, 32'h0C, mem_word(32'h0C), 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h1C, 32'h10, mem_word(32'h10), 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h20, 32'h14, mem_word(32'h14), 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h24, 32'h18, mem_word(32'h18), 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h28, 32'h00, NOP,              1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h2C, 32'h20, mem_word(32'h20), 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h30, 32'h24, mem_word(32'h24), 1'b1};

        imem_req_ready = 1'b1;
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            stall = vecs[i].stall;
            flush = vecs[i].flush;
            @(negedge clk);
            chk_req($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr);
            tick();
            chk_ifid($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].valid);
            $display("vec %0d: stall=%b flush=%b if_id pc=0x%08h instr=0x%08h valid=%b",
                     i, stall, flush, if_id_pc, if_id_instruction, if_id_valid);
        end
        stall = 1'b0;
        flush = 1'b0;

        // 3-cycle memory: redirect with two fetches in flight, then flush with 0x1004 at head.
        do_reset(3);
        @(negedge clk);
        chk_req("lat3_a", 1'b1, 32'h0);
        tick();
        @(negedge clk);
        chk_req("lat3_b", 1'b1, 32'h4);
        tick();
        #1;
        chk("max_outst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        pc_src = 1'b1;
        new_pc = 32'h0000_1000;
        tick();
        pc_src = 1'b0;
        chk("redir_bubble_valid", {31'b0, if_id_valid}, 32'h0);
        wait_valid("redir_first", 32'h0000_1000, 32'h1000_0237);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_ifid("flush", 32'h0, NOP, 1'b0);
        $display("flush: if_id pc=0x%08h instr=0x%08h valid=%b", if_id_pc, if_id_instruction, if_id_valid);
        wait_valid("after_flush", 32'h0000_1008, 32'h0050_0293);

        // Address wrap, misaligned redirect target, redirect under stall.
        do_reset(1);
        repeat (6) tick();
        pc_src = 1'b1;
        new_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
        tick();
        pc_src = 1'b0;
        @(negedge clk);
        chk_req("wrap_a", 1'b1, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk_req("wrap_b", 1'b1, 32'h0000_0000);
        tick();
        wait_valid("wrap_top", 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        tick();
        chk_ifid("wrap_zero", 32'h0, 32'h0000_0013, 1'b1);
        pc_src = 1'b1;
        new_pc = 32'h0000_1003;
        tick();
        pc_src = 1'b0;
        @(negedge clk);
        chk_req("misalign", 1'b1, 32'h0000_1000);
        wait_valid("misalign", 32'h0000_1000, 32'h1000_0237);
        stall  = 1'b1;
        pc_src = 1'b1;
        new_pc = 32'h0000_2000;
        tick();
        chk_ifid("stall_redir_hold", 32'h0000_1000, 32'h1000_0237, 1'b1);
        stall  = 1'b0;
        pc_src = 1'b0;
        tick();
        chk("stall_redir_bubble", {31'b0, if_id_valid}, 32'h0);
        wait_valid("stall_redir", 32'h0000_2000, mem_word(32'h0000_2000));

        // Memory not ready for 5 cycles, then reset in the middle of a burst.
        imem_req_ready = 1'b0;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_req($sformatf("not_ready%0d", i), 1'b1, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        wait_valid("ready_first", 32'h0, 32'h0000_0013);
        repeat (2) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        tick();
        chk_ifid("midrst", 32'h0, NOP, 1'b0);
        reset = 1'b0;
        wait_valid("after_midrst", 32'h0, 32'h0000_0013);
        tick();
        chk_ifid("after_midrst_next", 32'h4, 32'h0010_0093, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
